// File: rtl/angle_to_point.sv
// ---------------------------------------------------------------------------
// angle_to_point
//
// Purpose:
//   Converts a polar angle (degrees) and radius about a dial center into a
//   screen pixel coordinate on the 1280x720 frame. A multi-cycle FSM runs
//   quadrant fold, sine LUT lookup, radius multiply, offset/clamp and an
//   output strobe. This is the inverse of the centroid-to-angle path. Its
//   results feed the overlay that draws hand and shadow endpoints.
//
// Ports:
//   clk_in         system clock
//   rst_in         asynchronous active-low reset
//   data_valid_in  request strobe, sampled only while idle
//   angle_in       angle in degrees, legal 0..359 (0 = +x, 90 = +y)
//   radius_in      length in pixels
//   x0_in, y0_in   dial center
//   x_out, y_out   endpoint, held until the next valid result
//   clamped_out    endpoint was clipped on either axis
//   valid_out      one-cycle result strobe
//   error_out      one-cycle strobe for an illegal angle
//   busy_out       high while a request is in flight
// ---------------------------------------------------------------------------
module angle_to_point #(
    parameter int H_MAX = 1279,
    parameter int V_MAX = 719
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        data_valid_in,
    input  logic [8:0]  angle_in,
    input  logic [9:0]  radius_in,
    input  logic [10:0] x0_in,
    input  logic [9:0]  y0_in,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic        clamped_out,
    output logic        valid_out,
    output logic        error_out,
    output logic        busy_out
);

    localparam logic signed [12:0] XMAX13 = 13'(H_MAX);
    localparam logic signed [12:0] YMAX13 = 13'(V_MAX);
    localparam logic [10:0]        XMAX11 = 11'(H_MAX);
    localparam logic [9:0]         YMAX10 = 10'(V_MAX);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FOLD,
        ST_LOOKUP,
        ST_MULTIPLY,
        ST_OFFSET,
        ST_OUTPUT
    } state_t;

    state_t       r_state;
    logic [8:0]   r_angle;
    logic [9:0]   r_radius;
    logic [10:0]  r_x0;
    logic [9:0]   r_y0;
    logic [1:0]   r_quad;
    logic [6:0]   r_base;
    logic [8:0]   r_sin;
    logic [8:0]   r_cos;
    logic [9:0]   r_mSin;
    logic [9:0]   r_mCos;
    logic [10:0]  r_xRes;
    logic [9:0]   r_yRes;
    logic         r_clampRes;

    logic [8:0]          w_sinVal;
    logic [8:0]          w_cosVal;
    logic [18:0]         w_prodSin;
    logic [18:0]         w_prodCos;
    logic signed [12:0]  w_dx;
    logic signed [12:0]  w_dy;
    logic signed [12:0]  w_xs;
    logic signed [12:0]  w_ys;
    logic [10:0]         w_xClamp;
    logic [9:0]          w_yClamp;
    logic                w_clampAny;

    // round(256*sin(i deg)) for i = 0..90
    function automatic logic [8:0] sinLut(input logic [6:0] idx);
        logic [8:0] s;
        case (idx)
            7'd0:  s = 9'd0;   7'd1:  s = 9'd4;   7'd2:  s = 9'd9;   7'd3:  s = 9'd13;
            7'd4:  s = 9'd18;  7'd5:  s = 9'd22;  7'd6:  s = 9'd27;  7'd7:  s = 9'd31;
            7'd8:  s = 9'd36;  7'd9:  s = 9'd40;  7'd10: s = 9'd44;  7'd11: s = 9'd49;
            7'd12: s = 9'd53;  7'd13: s = 9'd58;  7'd14: s = 9'd62;  7'd15: s = 9'd66;
            7'd16: s = 9'd71;  7'd17: s = 9'd75;  7'd18: s = 9'd79;  7'd19: s = 9'd83;
            7'd20: s = 9'd88;  7'd21: s = 9'd92;  7'd22: s = 9'd96;  7'd23: s = 9'd100;
            7'd24: s = 9'd104; 7'd25: s = 9'd108; 7'd26: s = 9'd112; 7'd27: s = 9'd116;
            7'd28: s = 9'd120; 7'd29: s = 9'd124; 7'd30: s = 9'd128; 7'd31: s = 9'd132;
            7'd32: s = 9'd136; 7'd33: s = 9'd139; 7'd34: s = 9'd143; 7'd35: s = 9'd147;
            7'd36: s = 9'd150; 7'd37: s = 9'd154; 7'd38: s = 9'd158; 7'd39: s = 9'd161;
            7'd40: s = 9'd165; 7'd41: s = 9'd168; 7'd42: s = 9'd171; 7'd43: s = 9'd175;
            7'd44: s = 9'd178; 7'd45: s = 9'd181; 7'd46: s = 9'd184; 7'd47: s = 9'd187;
            7'd48: s = 9'd190; 7'd49: s = 9'd193; 7'd50: s = 9'd196; 7'd51: s = 9'd199;
            7'd52: s = 9'd202; 7'd53: s = 9'd204; 7'd54: s = 9'd207; 7'd55: s = 9'd210;
            7'd56: s = 9'd212; 7'd57: s = 9'd215; 7'd58: s = 9'd217; 7'd59: s = 9'd219;
            7'd60: s = 9'd222; 7'd61: s = 9'd224; 7'd62: s = 9'd226; 7'd63: s = 9'd228;
            7'd64: s = 9'd230; 7'd65: s = 9'd232; 7'd66: s = 9'd234; 7'd67: s = 9'd236;
            7'd68: s = 9'd237; 7'd69: s = 9'd239; 7'd70: s = 9'd241; 7'd71: s = 9'd242;
            7'd72: s = 9'd243; 7'd73: s = 9'd245; 7'd74: s = 9'd246; 7'd75: s = 9'd247;
            7'd76: s = 9'd248; 7'd77: s = 9'd249; 7'd78: s = 9'd250; 7'd79: s = 9'd251;
            7'd80: s = 9'd252; 7'd81: s = 9'd253; 7'd82: s = 9'd254; 7'd83: s = 9'd254;
            7'd84: s = 9'd255; 7'd85: s = 9'd255; 7'd86: s = 9'd255; 7'd87: s = 9'd256;
            7'd88: s = 9'd256; 7'd89: s = 9'd256; 7'd90: s = 9'd256;
            default: s = 9'd0;
        endcase
        return s;
    endfunction

    // Cosine of the folded angle is the sine of its complement
    assign w_sinVal  = sinLut(r_base);
    assign w_cosVal  = sinLut(7'd90 - r_base);

    // Half-up rounding: add 0.5 in Q8 before the shift
    assign w_prodSin = 19'(r_radius) * 19'(r_sin) + 19'd128;
    assign w_prodCos = 19'(r_radius) * 19'(r_cos) + 19'd128;

    // Quadrant sign application, offset from center, and per-axis clamp
    always_comb begin
        w_dx       = 13'sd0;
        w_dy       = 13'sd0;
        w_xClamp   = 11'd0;
        w_yClamp   = 10'd0;
        w_clampAny = 1'b0;
        case (r_quad)
            2'd0: begin
                w_dx = signed'({3'b000, r_mCos});
                w_dy = signed'({3'b000, r_mSin});
            end
            2'd1: begin
                w_dx = -signed'({3'b000, r_mSin});
                w_dy = signed'({3'b000, r_mCos});
            end
            2'd2: begin
                w_dx = -signed'({3'b000, r_mCos});
                w_dy = -signed'({3'b000, r_mSin});
            end
            default: begin
                w_dx = signed'({3'b000, r_mSin});
                w_dy = -signed'({3'b000, r_mCos});
            end
        endcase
        w_xs = signed'({2'b00, r_x0}) + w_dx;
        w_ys = signed'({3'b000, r_y0}) + w_dy;
        if (w_xs < 13'sd0) begin
            w_xClamp   = 11'd0;
            w_clampAny = 1'b1;
        end else if (w_xs > XMAX13) begin
            w_xClamp   = XMAX11;
            w_clampAny = 1'b1;
        end else begin
            w_xClamp   = w_xs[10:0];
        end
        if (w_ys < 13'sd0) begin
            w_yClamp   = 10'd0;
            w_clampAny = 1'b1;
        end else if (w_ys > YMAX13) begin
            w_yClamp   = YMAX10;
            w_clampAny = 1'b1;
        end else begin
            w_yClamp   = w_ys[9:0];
        end
    end

    // Main FSM: one pipeline step per state; busy_out is the previous cycle's
    // non-idle status so it covers the valid_out cycle as well.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state     <= ST_IDLE;
            r_angle     <= '0;
            r_radius    <= '0;
            r_x0        <= '0;
            r_y0        <= '0;
            r_quad      <= '0;
            r_base      <= '0;
            r_sin       <= '0;
            r_cos       <= '0;
            r_mSin      <= '0;
            r_mCos      <= '0;
            r_xRes      <= '0;
            r_yRes      <= '0;
            r_clampRes  <= 1'b0;
            x_out       <= '0;
            y_out       <= '0;
            clamped_out <= 1'b0;
            valid_out   <= 1'b0;
            error_out   <= 1'b0;
            busy_out    <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            error_out <= 1'b0;
            busy_out  <= (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (data_valid_in) begin
                        r_angle  <= angle_in;
                        r_radius <= radius_in;
                        r_x0     <= x0_in;
                        r_y0     <= y0_in;
                        if (angle_in >= 9'd360) begin
                            error_out <= 1'b1;
                        end else begin
                            r_state <= ST_FOLD;
                        end
                    end
                end
                ST_FOLD: begin
                    if (r_angle >= 9'd270) begin
                        r_quad <= 2'd3;
                        r_base <= 7'(r_angle - 9'd270);
                    end else if (r_angle >= 9'd180) begin
                        r_quad <= 2'd2;
                        r_base <= 7'(r_angle - 9'd180);
                    end else if (r_angle >= 9'd90) begin
                        r_quad <= 2'd1;
                        r_base <= 7'(r_angle - 9'd90);
                    end else begin
                        r_quad <= 2'd0;
                        r_base <= 7'(r_angle);
                    end
                    r_state <= ST_LOOKUP;
                end
                ST_LOOKUP: begin
                    r_sin   <= w_sinVal;
                    r_cos   <= w_cosVal;
                    r_state <= ST_MULTIPLY;
                end
                ST_MULTIPLY: begin
                    r_mSin  <= 10'(w_prodSin >> 8);
                    r_mCos  <= 10'(w_prodCos >> 8);
                    r_state <= ST_OFFSET;
                end
                ST_OFFSET: begin
                    r_xRes     <= w_xClamp;
                    r_yRes     <= w_yClamp;
                    r_clampRes <= w_clampAny;
                    r_state    <= ST_OUTPUT;
                end
                ST_OUTPUT: begin
                    x_out       <= r_xRes;
                    y_out       <= r_yRes;
                    clamped_out <= r_clampRes;
                    valid_out   <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
